// File: rtl/ahb_rom_fetcher.sv
// AHB-Lite read master: streams a block of ROM words into a local FIFO and out on valid/ready.
// Latency: start -> NONSEQ 1 cycle -> data sampled 2 cycles -> rd_valid 3 cycles.
// Backpressure: address phases issue only while FIFO credit remains; rd_ready stalls drain only.
module ahb_rom_fetcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 13,
    parameter int CW         = 11
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [CW-1:0] word_cnt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          HSEL,
    output logic [1:0]    HTRANS,
    output logic [AW-1:0] HADDR,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    input  logic          HREADY,
    input  logic          HRESP,
    input  logic [31:0]   HRDATA,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    input  logic          rd_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic            err_q, err_d;
    logic            outst_q, outst_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [31:0]     mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [NW-1:0]   cnt_q, cnt_d;

    logic [NW:0]     used;
    logic            credit_ok;
    logic            nonseq;
    logic            data_err;
    logic            addr_acc;
    logic            push;
    logic            pop;

    // Byte offset of the start address is discarded; the bus is word-only.
    logic [1:0]      unused_addr_lsb;
    assign unused_addr_lsb = start_addr[1:0];

    // Credit gating, bus-phase tracking, FIFO update and command FSM.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        err_d    = err_q;
        outst_d  = outst_q;
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;

        // Credit uses only registered occupancy, so a pop this cycle frees a slot next cycle.
        used      = {1'b0, cnt_q} + {{NW{1'b0}}, outst_q};
        credit_ok = used < (NW+1)'(FIFO_DEPTH);
        nonseq    = (state_q == S_ADDR) && credit_ok;
        data_err  = outst_q && HRESP;
        addr_acc  = nonseq && HREADY && !data_err;
        push      = outst_q && HREADY && !HRESP;
        pop       = (cnt_q != '0) && rd_ready;

        // At most one data phase is ever pending; a new address replaces a completing one.
        if (data_err)
            outst_d = 1'b0;
        else if (addr_acc)
            outst_d = 1'b1;
        else if (HREADY)
            outst_d = 1'b0;

        if (push) begin
            mem_d[wptr_q] = HRDATA;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop)
            rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + NW'(1);
            2'b01:   cnt_d = cnt_q - NW'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d    = 1'b0;
                    addr_d   = {start_addr[AW-1:2], 2'b00};
                    remain_d = word_cnt;
                    state_d  = (word_cnt == '0) ? S_FIN : S_ADDR;
                end
            end
            S_ADDR: begin
                if (data_err) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (addr_acc) begin
                    addr_d   = addr_q + AW'(4);
                    remain_d = remain_q - CW'(1);
                    if (remain_q == CW'(1))
                        state_d = S_LAST;
                end
            end
            S_LAST: begin
                if (data_err) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (outst_q && HREADY) begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any command and flushes the FIFO.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            err_q    <= 1'b0;
            outst_q  <= 1'b0;
            mem_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            err_q    <= err_d;
            outst_q  <= outst_d;
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign HTRANS   = nonseq ? 2'b10 : 2'b00;
    assign HSEL     = nonseq;
    assign HADDR    = addr_q;
    assign HWRITE   = 1'b0;
    assign HSIZE    = 3'b010;
    assign HBURST   = 3'b000;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign err      = err_q;
    assign rd_data  = mem_q[rptr_q];
    assign rd_valid = (cnt_q != '0);

endmodule

// File: tb/tb_ahb_rom_fetcher.sv
// Bench for ahb_rom_fetcher: ROM slave model, address and data scoreboards, directed scenarios.
// Latency: n/a (bench).
// Backpressure: bench drives HREADY wait states and rd_ready stalls.
module tb_ahb_rom_fetcher;

    localparam int AW = 13;
    localparam int CW = 11;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] word_cnt;
    logic          busy, done, err, HSEL, HWRITE;
    logic [1:0]    HTRANS;
    logic [AW-1:0] HADDR;
    logic [2:0]    HSIZE, HBURST;
    logic          HREADY, HRESP;
    logic [31:0]   HRDATA;
    logic [31:0]   rd_data;
    logic          rd_valid, rd_ready;

    logic          hready_tb;
    logic [AW-1:0] dp_addr = '0;
    int            err_ph  = 0;
    logic          err_en  = 1'b0;
    logic [AW-1:0] err_addr = '0;

    logic [31:0]   exp_d[$];
    logic [AW-1:0] exp_a[$];
    int checks = 0, failures = 0, done_cnt = 0, acc_cnt = 0;
    int base_acc, base_done;

    ahb_rom_fetcher #(.FIFO_DEPTH(4), .AW(AW), .CW(CW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .start_addr(start_addr),
        .word_cnt(word_cnt), .busy(busy), .done(done), .err(err), .HSEL(HSEL),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] rom(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {19'd0, a};
    endfunction

    // ROM slave: data phase follows the accepted address; optional two-cycle ERROR on err_addr.
    assign HREADY = hready_tb && (err_ph != 1);
    assign HRESP  = (err_ph == 1) || (err_ph == 2);
    assign HRDATA = rom(dp_addr);

    always @(posedge HCLK) begin
        if (HREADY) dp_addr <= HADDR;
        case (err_ph)
            0: if (err_en && HREADY && HTRANS == 2'b10 && HADDR == err_addr) err_ph <= 1;
            1: err_ph <= 2;
            default: err_ph <= 0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboards for popped words and accepted address phases.
    always @(negedge HCLK) begin
        if (rd_valid && rd_ready) begin
            if (exp_d.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_word: got %h expected none", rd_data);
            end else chk("rd_data", rd_data, exp_d.pop_front());
        end
        if (HTRANS == 2'b10 && HREADY && !HRESET) begin
            acc_cnt++;
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_addr: got %h expected none", HADDR);
            end else chk("haddr", {19'd0, HADDR}, {19'd0, exp_a.pop_front()});
            chk("ctrl", {24'd0, HSEL, HWRITE, HSIZE, HBURST}, {24'd0, 1'b1, 1'b0, 3'b010, 3'b000});
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] a, input int n, input int na, input int nd);
        logic [AW-1:0] ad;
        ad = a;
        for (int i = 0; i < na; i++) begin
            exp_a.push_back(ad);
            if (i < nd) exp_d.push_back(rom(ad));
            ad = ad + AW'(4);
        end
        start = 1'b1; start_addr = a; word_cnt = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge HCLK);
            if (!busy && !rd_valid) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_idle: busy=%b rd_valid=%b still set after %0d cycles", busy, rd_valid, max);
        end
        tick();
    endtask

    task automatic chk_empty(input string name);
        chk({name, "_exp_d_left"}, exp_d.size(), 0);
        chk({name, "_exp_a_left"}, exp_a.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1; start = 1'b0; start_addr = '0; word_cnt = '0;
        rd_ready = 1'b0; hready_tb = 1'b1;
        repeat (3) tick();
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_hsel", HSEL, 0);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_rd_valid", rd_valid, 0);
        tick();

        // 1: wrap at top of window, full rate, exact per-cycle timing
        rd_ready = 1'b1;
        issue(13'h1FF8, 4, 4, 4);
        for (int c = 1; c <= 6; c++) begin
            @(negedge HCLK);
            chk($sformatf("t1_htrans_c%0d", c), HTRANS, (c <= 4) ? 2 : 0);
            chk($sformatf("t1_rd_valid_c%0d", c), rd_valid, (c >= 3) ? 1 : 0);
            chk($sformatf("t1_done_c%0d", c), done, (c == 6) ? 1 : 0);
            tick();
        end
        wait_idle(20);
        chk_empty("t1");

        // 2: consumer stalled -> credit limits to FIFO depth
        rd_ready = 1'b0;
        base_acc = acc_cnt;
        issue(13'h0040, 8, 8, 8);
        repeat (8) tick();
        @(negedge HCLK);
        chk("t2_nonseq_stalled", acc_cnt - base_acc, 4);
        chk("t2_htrans_idle", HTRANS, 0);
        chk("t2_busy", busy, 1);
        tick();
        rd_ready = 1'b1;
        wait_idle(50);
        chk("t2_nonseq_total", acc_cnt - base_acc, 8);
        chk_empty("t2");

        // 3: two wait states mid-burst hold the address phase
        base_acc = acc_cnt;
        issue(13'h0200, 8, 8, 8);
        tick();
        tick();
        hready_tb = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge HCLK);
            chk($sformatf("t3_htrans_hold%0d", k), HTRANS, 2);
            chk($sformatf("t3_haddr_hold%0d", k), HADDR, 13'h0208);
            tick();
        end
        hready_tb = 1'b1;
        wait_idle(50);
        chk("t3_nonseq_total", acc_cnt - base_acc, 8);
        chk_empty("t3");

        // 4: ERROR on the third word cancels the rest
        base_acc = acc_cnt; base_done = done_cnt;
        err_addr = 13'h0108; err_en = 1'b1;
        issue(13'h0100, 6, 3, 2);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge HCLK);
                if (HRESP && !HREADY) seen = 1'b1;
                else tick();
            end
            chk("t4_error_seen", seen, 1);
        end
        tick();
        @(negedge HCLK);
        chk("t4_htrans_idle", HTRANS, 0);
        chk("t4_done", done, 1);
        chk("t4_err", err, 1);
        tick();
        err_en = 1'b0;
        wait_idle(20);
        chk("t4_done_pulses", done_cnt - base_done, 1);
        chk("t4_err_sticky", err, 1);
        chk("t4_nonseq_total", acc_cnt - base_acc, 3);
        chk_empty("t4");

        // 5: zero-length command, second start while busy is ignored
        base_acc = acc_cnt; base_done = done_cnt;
        issue(13'h0400, 0, 0, 0);
        start = 1'b1; word_cnt = CW'(3);
        @(negedge HCLK);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 1);
        chk("t5_err_cleared", err, 0);
        chk("t5_htrans", HTRANS, 0);
        tick();
        start = 1'b0;
        @(negedge HCLK);
        chk("t5_busy_after", busy, 0);
        chk("t5_done_after", done, 0);
        repeat (5) tick();
        chk("t5_no_nonseq", acc_cnt - base_acc, 0);
        chk("t5_done_pulses", done_cnt - base_done, 1);

        // 6: reset mid-command aborts without done
        rd_ready = 1'b0;
        base_done = done_cnt;
        issue(13'h0300, 5, 5, 5);
        tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        exp_a.delete();
        exp_d.delete();
        @(negedge HCLK);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_hsel", HSEL, 0);
        chk("t6_htrans", HTRANS, 0);
        chk("t6_haddr", HADDR, 0);
        chk("t6_rd_valid", rd_valid, 0);
        repeat (6) tick();
        chk("t6_no_done", done_cnt - base_done, 0);
        chk("t6_still_empty", rd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
